// File: rtl/cache_refill_ctrl.sv
// Direct-mapped read cache controller: one-cycle tag lookup, and on a miss an
// in-order, one-word-outstanding line refill from backing memory.
`timescale 1ns/1ps
module cache_refill_ctrl #(
  parameter int TAG_W = 18,
  parameter int IDX_W = 8,
  parameter int WPL   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_hit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int OFF_W    = $clog2(WPL);
  localparam int LINES    = 1 << IDX_W;
  localparam int LINE_LSB = OFF_W + 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    REFILL  = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t                   state;
  state_t                   next_state;
  logic [31:2]              addr;
  logic [OFF_W-1:0]         cnt;
  logic [LINES-1:0]         valid;
  logic [TAG_W-1:0]         tag_mem  [LINES];
  logic [31:0]              data_mem [LINES*WPL];

  logic [TAG_W-1:0]         addr_tag;
  logic [IDX_W-1:0]         idx;
  logic [OFF_W-1:0]         off;
  logic [IDX_W+OFF_W-1:0]   rd_ptr;
  logic [IDX_W+OFF_W-1:0]   wr_ptr;
  logic                     hit;
  logic                     last_beat;
  logic                     unused_addr_bits;

  // Byte-lane bits never select anything in a word-wide read cache.
  assign unused_addr_bits = ^req_addr[1:0];

  assign addr_tag  = addr[31 -: TAG_W];
  assign idx       = addr[LINE_LSB +: IDX_W];
  assign off       = addr[2 +: OFF_W];
  assign rd_ptr    = {idx, off};
  assign wr_ptr    = {idx, cnt};
  assign hit       = valid[idx] && (tag_mem[idx] == addr_tag);
  assign last_beat = (cnt == OFF_W'(WPL - 1));

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = LOOKUP; else next_state = IDLE;
      LOOKUP:  if (hit) next_state = RESPOND; else next_state = REFILL;
      REFILL:  if (mem_rvalid && last_beat) next_state = RESPOND; else next_state = REFILL;
      RESPOND: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, request capture, handshake outputs, refill bookkeeping and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= 30'd0;
      cnt        <= '0;
      valid      <= '0;
      hit_cnt    <= 16'd0;
      miss_cnt   <= 16'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_data  <= 32'd0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'd0;
    end else begin
      state      <= next_state;
      req_ready  <= (next_state == IDLE);
      resp_valid <= (next_state == RESPOND);
      mem_req    <= (next_state == REFILL);
      case (state)
        IDLE: begin
          if (req_valid) addr <= req_addr[31:2];
        end
        LOOKUP: begin
          if (hit) begin
            resp_data <= data_mem[rd_ptr];
            resp_hit  <= 1'b1;
            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
          end else begin
            valid[idx] <= 1'b0;
            cnt        <= '0;
            mem_addr   <= {addr[31:LINE_LSB], {OFF_W{1'b0}}, 2'b00};
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
          end
        end
        REFILL: begin
          if (mem_rvalid) begin
            cnt      <= cnt + OFF_W'(1);
            mem_addr <= {addr[31:LINE_LSB], cnt + OFF_W'(1), 2'b00};
            if (last_beat) begin
              valid[idx] <= 1'b1;
              resp_hit   <= 1'b0;
              // The requested word is already in the array unless it is this final beat.
              resp_data  <= (off == OFF_W'(WPL - 1)) ? mem_rdata : data_mem[rd_ptr];
            end
          end
        end
        RESPOND: begin
          resp_hit <= resp_hit;
        end
        default: begin
          resp_hit <= resp_hit;
        end
      endcase
    end
  end

  // Data and tag arrays; deliberately not reset, only the valid vector is.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_rvalid) begin
      data_mem[wr_ptr] <= mem_rdata;
      if (last_beat) tag_mem[idx] <= addr_tag;
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: table of reads with hand-computed results
// against a word-indexed memory model, plus reset-abort and saturation sequences.
`timescale 1ns/1ps
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  typedef struct packed {
    logic [31:0] addr;
    logic        hit;
    logic [31:0] data;
    logic [15:0] hits;
    logic [15:0] misses;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          max_dly = 0;
  int          beats = 0;
  int          beat_limit = 1000000;
  int          stray_go = 0;
  int          stray_done = 0;
  int          last_ok_cnt = 0;
  logic [31:0] beat_addrs[$];
  vec_t        tbl [10];

  cache_refill_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_hit   (resp_hit),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: word k of the address space reads as 0xA000_0000 + k, after 0..max_dly idle cycles.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (mem_req && !rst && beats < beat_limit) begin
        repeat ($urandom_range(max_dly, 0)) begin @(posedge clk); #1; end
        if (mem_req) begin
          mem_rdata = 32'hA000_0000 + {2'b00, mem_addr[31:2]};
          beat_addrs.push_back(mem_addr);
          beats++;
          mem_rvalid = 1'b1;
          @(posedge clk); #1;
          mem_rvalid = 1'b0;
          if (!mem_req && resp_valid) last_ok_cnt++;
        end
      end else if (stray_done != stray_go) begin
        mem_rdata  = 32'hDEAD_BEEF;
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        stray_done++;
      end
    end
  end

  task automatic do_read(input vec_t v, input string name);
    int          n0;
    int          ok0;
    int          edges;
    logic        saw_req;
    logic [31:0] base;
    n0    = beat_addrs.size();
    ok0   = last_ok_cnt;
    edges = 0;
    while (!req_ready && edges < 50) begin @(posedge clk); #1; edges++; end
    check({name, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = ~v.addr;
    edges   = 1;
    saw_req = 1'b0;
    while (!resp_valid && edges < 400) begin
      saw_req |= mem_req;
      @(posedge clk); #1;
      edges++;
    end
    check({name, ".resp_valid"}, 32'(resp_valid), 32'd1);
    check({name, ".resp_hit"}, 32'(resp_hit), 32'(v.hit));
    check({name, ".resp_data"}, resp_data, v.data);
    check({name, ".hit_cnt"}, 32'(hit_cnt), 32'(v.hits));
    check({name, ".miss_cnt"}, 32'(miss_cnt), 32'(v.misses));
    if (v.hit) begin
      check({name, ".hit_latency"}, 32'(edges), 32'd2);
      check({name, ".no_mem_req"}, 32'(saw_req), 32'd0);
    end else begin
      base = {v.addr[31:6], 6'd0};
      check({name, ".beats"}, 32'(beat_addrs.size() - n0), 32'd16);
      for (int i = 0; i < 16; i++) begin
        if (n0 + i < beat_addrs.size())
          check($sformatf("%s.refill_addr%0d", name, i), beat_addrs[n0 + i], base + 32'(4 * i));
      end
    end
    @(posedge clk); #1;
    check({name, ".strobe_1cyc"}, 32'(resp_valid), 32'd0);
    check({name, ".data_hold"}, resp_data, v.data);
    check({name, ".hit_hold"}, 32'(resp_hit), 32'(v.hit));
    if (!v.hit) check({name, ".miss_latency"}, 32'(last_ok_cnt - ok0), 32'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, ".req_ready"}, 32'(req_ready), 32'd1);
    check({name, ".resp_valid"}, 32'(resp_valid), 32'd0);
    check({name, ".resp_hit"}, 32'(resp_hit), 32'd0);
    check({name, ".resp_data"}, resp_data, 32'd0);
    check({name, ".mem_req"}, 32'(mem_req), 32'd0);
    check({name, ".mem_addr"}, mem_addr, 32'd0);
    check({name, ".hit_cnt"}, 32'(hit_cnt), 32'd0);
    check({name, ".miss_cnt"}, 32'(miss_cnt), 32'd0);
  endtask

  initial begin
    int   k;
    vec_t v;
    tbl[0] = '{32'h0000_0048, 1'b0, 32'hA000_0012, 16'd0, 16'd1};
    tbl[1] = '{32'h0000_004C, 1'b1, 32'hA000_0013, 16'd1, 16'd1};
    tbl[2] = '{32'h0000_4048, 1'b0, 32'hA000_1012, 16'd1, 16'd2};
    tbl[3] = '{32'h0000_0048, 1'b0, 32'hA000_0012, 16'd1, 16'd3};
    tbl[4] = '{32'h0000_007C, 1'b1, 32'hA000_001F, 16'd2, 16'd3};
    tbl[5] = '{32'h0000_0040, 1'b1, 32'hA000_0010, 16'd3, 16'd3};
    tbl[6] = '{32'h0001_2344, 1'b0, 32'hA000_48D1, 16'd3, 16'd4};
    tbl[7] = '{32'h0002_00FC, 1'b0, 32'hA000_803F, 16'd3, 16'd5};
    tbl[8] = '{32'h0001_2340, 1'b1, 32'hA000_48D0, 16'd4, 16'd5};
    tbl[9] = '{32'h0002_00C0, 1'b1, 32'hA000_8030, 16'd5, 16'd5};

    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst     = 1'b0;
    max_dly = 2;
    for (int i = 0; i < 10; i++) do_read(tbl[i], $sformatf("vec%0d", i));

    // Reset after the 7th refill beat must abandon the line.
    beat_limit = beats + 7;
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0800;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (beats < beat_limit && k < 300) begin @(posedge clk); #1; k++; end
    check("abort.seven_beats", 32'(beats), 32'(beat_limit));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort.still_refilling", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort_rst");
    @(posedge clk); #1;
    rst        = 1'b0;
    beat_limit = 1000000;
    v = '{32'h0000_0800, 1'b0, 32'hA000_0200, 16'd0, 16'd1};
    do_read(v, "reissue");
    v = '{32'h0000_0048, 1'b0, 32'hA000_0012, 16'd0, 16'd2};
    do_read(v, "valid_cleared");

    // Stray read data while idle must be ignored.
    max_dly = 5;
    stray_go++;
    k = 0;
    while (stray_done != stray_go && k < 20) begin @(posedge clk); #1; k++; end
    check("stray.done", 32'(stray_done), 32'(stray_go));
    @(posedge clk); #1;
    check("stray.req_ready", 32'(req_ready), 32'd1);
    check("stray.mem_req", 32'(mem_req), 32'd0);
    check("stray.resp_valid", 32'(resp_valid), 32'd0);
    check("stray.hit_cnt", 32'(hit_cnt), 32'd0);
    check("stray.miss_cnt", 32'(miss_cnt), 32'd2);
    v = '{32'h0000_0800, 1'b1, 32'hA000_0200, 16'd1, 16'd2};
    do_read(v, "after_stray");

    force dut.hit_cnt = 16'hFFFE;
    @(posedge clk); #1;
    release dut.hit_cnt;
    @(posedge clk); #1;
    check("preload", 32'(hit_cnt), 32'h0000_FFFE);
    v = '{32'h0000_0804, 1'b1, 32'hA000_0201, 16'hFFFF, 16'd2};
    do_read(v, "sat0");
    v = '{32'h0000_083C, 1'b1, 32'hA000_020F, 16'hFFFF, 16'd2};
    do_read(v, "sat1");
    v = '{32'h0000_0048, 1'b1, 32'hA000_0012, 16'hFFFF, 16'd2};
    do_read(v, "sat2");
    v = '{32'h0000_4048, 1'b0, 32'hA000_1012, 16'hFFFF, 16'd3};
    do_read(v, "rand_dly_miss");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
